// File: rtl/radio_enable_sequencer_if.sv
// Request/enable bundle between the SPI register bank, the PLL and the Stage2 enable block.
interface radio_enable_sequencer_if #(
  parameter int SIZE_SPISLAVE_T_ARSTFS = 8
);
  logic                              radioEnableReq;
  logic                              radioRxEnReq;
  logic                              pllSettled;
  logic [SIZE_SPISLAVE_T_ARSTFS-1:0] tArstFs;
  logic                              radioEnableSynced;
  logic                              radioRxEnSynced;
  logic                              busy;

  modport master (
    output radioEnableReq, radioRxEnReq, pllSettled, tArstFs,
    input  radioEnableSynced, radioRxEnSynced, busy
  );

  modport slave (
    input  radioEnableReq, radioRxEnReq, pllSettled, tArstFs,
    output radioEnableSynced, radioRxEnSynced, busy
  );
endinterface

// File: rtl/radio_enable_sequencer.sv
// Timing Engine Stage1: synchronizes radio enable/RX requests and grants enable after PLL settle + tArstFs.
// Optional feature macro: TE_PLL_LOSS_ABORT_EN (PLL loss in DELAY/ACTIVE returns to WAIT_PLL).
module radio_enable_sequencer #(
  parameter int SIZE_SPISLAVE_T_ARSTFS = 8,
  parameter int SYNC_STAGES            = 2
) (
  input  logic                   clk,
  input  logic                   rstN,
  radio_enable_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_PLL = 2'b01,
    DELAY    = 2'b10,
    ACTIVE   = 2'b11
  } state_e;

  localparam logic [SIZE_SPISLAVE_T_ARSTFS-1:0] CNT_ONE = SIZE_SPISLAVE_T_ARSTFS'(1);

  state_e                            state_q, state_d;
  logic [SIZE_SPISLAVE_T_ARSTFS-1:0] cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0]            en_sync_q, rx_sync_q;
  logic                              en_sync_s, rx_sync_s, pll_lost_s;
  logic                              enable_q, rx_en_q, busy_q;

  assign en_sync_s = en_sync_q[SYNC_STAGES-1];
  assign rx_sync_s = rx_sync_q[SYNC_STAGES-1];

`ifdef TE_PLL_LOSS_ABORT_EN
  assign pll_lost_s = ~bus.pllSettled;
`else
  assign pll_lost_s = 1'b0;
`endif

  // Request synchronizer chains; the only logic touching the raw async inputs.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      en_sync_q <= '0;
      rx_sync_q <= '0;
    end else begin
      en_sync_q <= {en_sync_q[SYNC_STAGES-2:0], bus.radioEnableReq};
      rx_sync_q <= {rx_sync_q[SYNC_STAGES-2:0], bus.radioRxEnReq};
    end
  end

  // Next-state and delay-counter logic; a dropped request wins over everything else.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!en_sync_s) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_PLL;
        end
        WAIT_PLL: begin
          if (!bus.pllSettled) begin
            state_d = WAIT_PLL;
          end else if (bus.tArstFs == '0) begin
            state_d = ACTIVE;
          end else begin
            state_d = DELAY;
            cnt_d   = bus.tArstFs;
          end
        end
        DELAY: begin
          if (pll_lost_s) begin
            state_d = WAIT_PLL;
            cnt_d   = '0;
          end else if (cnt_q == CNT_ONE) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q - CNT_ONE;
          end
        end
        ACTIVE: begin
          if (pll_lost_s) begin
            state_d = WAIT_PLL;
          end else begin
            state_d = ACTIVE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and outputs; outputs are registered decodes of the next state.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      enable_q <= 1'b0;
      rx_en_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      enable_q <= (state_d == ACTIVE);
      rx_en_q  <= (state_d == ACTIVE) & rx_sync_s;
      busy_q   <= (state_d == WAIT_PLL) | (state_d == DELAY);
    end
  end

  assign bus.radioEnableSynced = enable_q;
  assign bus.radioRxEnSynced   = rx_en_q;
  assign bus.busy              = busy_q;

endmodule

// File: tb/tb_radio_enable_sequencer.sv
// Directed self-checking bench for radio_enable_sequencer (SYNC_STAGES=2); honours TE_PLL_LOSS_ABORT_EN.
module tb_radio_enable_sequencer;

  localparam int W = 8;
`ifdef TE_PLL_LOSS_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstN;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  radio_enable_sequencer_if #(.SIZE_SPISLAVE_T_ARSTFS(W)) bus ();

  radio_enable_sequencer #(.SIZE_SPISLAVE_T_ARSTFS(W), .SYNC_STAGES(2)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bus.radioEnableReq = 1'b0;
    bus.radioRxEnReq   = 1'b0;
    tick(6);
    total_cnt++;
    if (bus.radioEnableSynced !== 1'b0) $display("FAIL idle_en: got %b expected 0", bus.radioEnableSynced);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    bus.radioEnableReq = 1'b0;
    bus.radioRxEnReq   = 1'b0;
    bus.pllSettled     = 1'b0;
    bus.tArstFs        = 8'd0;
    #2;
    total_cnt++;
    if ({bus.radioEnableSynced, bus.radioRxEnSynced, bus.busy} !== 3'b000)
      $display("FAIL reset_outs: got %b expected 000", {bus.radioEnableSynced, bus.radioRxEnSynced, bus.busy});
    else pass_cnt++;
    bus.radioEnableReq = 1'b1;
    bus.pllSettled     = 1'b1;
    tick(3);
    total_cnt++;
    if ({bus.radioEnableSynced, bus.busy} !== 2'b00)
      $display("FAIL reset_held: got %b expected 00", {bus.radioEnableSynced, bus.busy});
    else pass_cnt++;
    bus.radioEnableReq = 1'b0;
    rstN = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    logic exp_en, exp_busy;
    bus.tArstFs        = 8'd5;
    bus.pllSettled     = 1'b1;
    bus.radioEnableReq = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick(1);
      exp_en   = (e >= 9);
      exp_busy = (e >= 3) && (e <= 8);
      total_cnt++;
      if (bus.radioEnableSynced !== exp_en) $display("FAIL basic_en edge %0d: got %b expected %b", e, bus.radioEnableSynced, exp_en);
      else pass_cnt++;
      total_cnt++;
      if (bus.busy !== exp_busy) $display("FAIL basic_busy edge %0d: got %b expected %b", e, bus.busy, exp_busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_zero_delay();
    logic exp_en, exp_busy;
    bus.tArstFs        = 8'd0;
    bus.pllSettled     = 1'b1;
    bus.radioEnableReq = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick(1);
      exp_en   = (e >= 4);
      exp_busy = (e == 3);
      total_cnt++;
      if (bus.radioEnableSynced !== exp_en) $display("FAIL zero_en edge %0d: got %b expected %b", e, bus.radioEnableSynced, exp_en);
      else pass_cnt++;
      total_cnt++;
      if (bus.busy !== exp_busy) $display("FAIL zero_busy edge %0d: got %b expected %b", e, bus.busy, exp_busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_pll_wait();
    logic exp_en, exp_busy;
    bus.tArstFs        = 8'd3;
    bus.pllSettled     = 1'b0;
    bus.radioEnableReq = 1'b1;
    for (int e = 1; e <= 23; e++) begin
      tick(1);
      exp_busy = (e >= 3);
      total_cnt++;
      if (bus.radioEnableSynced !== 1'b0) $display("FAIL pllwait_en edge %0d: got %b expected 0", e, bus.radioEnableSynced);
      else pass_cnt++;
      total_cnt++;
      if (bus.busy !== exp_busy) $display("FAIL pllwait_busy edge %0d: got %b expected %b", e, bus.busy, exp_busy);
      else pass_cnt++;
    end
    bus.pllSettled = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick(1);
      exp_en   = (e >= 4);
      exp_busy = (e <= 3);
      total_cnt++;
      if (bus.radioEnableSynced !== exp_en) $display("FAIL pllrise_en edge %0d: got %b expected %b", e, bus.radioEnableSynced, exp_en);
      else pass_cnt++;
      total_cnt++;
      if (bus.busy !== exp_busy) $display("FAIL pllrise_busy edge %0d: got %b expected %b", e, bus.busy, exp_busy);
      else pass_cnt++;
      // Changing the delay after the count was loaded must not stretch it.
      if (e == 1) bus.tArstFs = 8'd200;
    end
  endtask

  task automatic test_rx_toggle();
    logic exp_en, exp_rx;
    bus.radioRxEnReq = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick(1);
      exp_rx = (e >= 3);
      total_cnt++;
      if (bus.radioRxEnSynced !== exp_rx) $display("FAIL rx_rise edge %0d: got %b expected %b", e, bus.radioRxEnSynced, exp_rx);
      else pass_cnt++;
    end
    bus.radioEnableReq = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick(1);
      exp_en = (e < 3);
      exp_rx = (e < 3);
      total_cnt++;
      if (bus.radioEnableSynced !== exp_en) $display("FAIL fall_en edge %0d: got %b expected %b", e, bus.radioEnableSynced, exp_en);
      else pass_cnt++;
      total_cnt++;
      if (bus.radioRxEnSynced !== exp_rx) $display("FAIL fall_rx edge %0d: got %b expected %b", e, bus.radioRxEnSynced, exp_rx);
      else pass_cnt++;
      total_cnt++;
      if (bus.radioRxEnSynced && !bus.radioEnableSynced) $display("FAIL rx_outlives_en edge %0d: got rx=1 en=0 expected rx<=en", e);
      else pass_cnt++;
    end
    bus.radioRxEnReq = 1'b0;
    tick(4);
  endtask

  task automatic test_abort();
    logic exp_en, exp_busy;
    bus.tArstFs        = 8'd10;
    bus.pllSettled     = 1'b1;
    bus.radioEnableReq = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick(1);
      exp_busy = (e >= 3) && (e <= 8);
      total_cnt++;
      if (bus.radioEnableSynced !== 1'b0) $display("FAIL abort_en edge %0d: got %b expected 0", e, bus.radioEnableSynced);
      else pass_cnt++;
      total_cnt++;
      if (bus.busy !== exp_busy) $display("FAIL abort_busy edge %0d: got %b expected %b", e, bus.busy, exp_busy);
      else pass_cnt++;
      if (e == 6) bus.radioEnableReq = 1'b0;
    end
    bus.radioEnableReq = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick(1);
      exp_en   = (e >= 14);
      exp_busy = (e >= 3) && (e <= 13);
      total_cnt++;
      if (bus.radioEnableSynced !== exp_en) $display("FAIL rereq_en edge %0d: got %b expected %b", e, bus.radioEnableSynced, exp_en);
      else pass_cnt++;
      total_cnt++;
      if (bus.busy !== exp_busy) $display("FAIL rereq_busy edge %0d: got %b expected %b", e, bus.busy, exp_busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_pll_loss();
    logic exp_en, exp_busy;
    bus.pllSettled = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick(1);
      exp_en   = !ABORT_EN;
      exp_busy = ABORT_EN;
      total_cnt++;
      if (bus.radioEnableSynced !== exp_en) $display("FAIL pllloss_en edge %0d: got %b expected %b", e, bus.radioEnableSynced, exp_en);
      else pass_cnt++;
      total_cnt++;
      if (bus.busy !== exp_busy) $display("FAIL pllloss_busy edge %0d: got %b expected %b", e, bus.busy, exp_busy);
      else pass_cnt++;
    end
    bus.pllSettled = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick(1);
      exp_en   = ABORT_EN ? (e >= 11) : 1'b1;
      exp_busy = ABORT_EN ? (e <= 10) : 1'b0;
      total_cnt++;
      if (bus.radioEnableSynced !== exp_en) $display("FAIL pllback_en edge %0d: got %b expected %b", e, bus.radioEnableSynced, exp_en);
      else pass_cnt++;
      total_cnt++;
      if (bus.busy !== exp_busy) $display("FAIL pllback_busy edge %0d: got %b expected %b", e, bus.busy, exp_busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    logic exp_en, exp_busy;
    bus.radioRxEnReq = 1'b1;
    tick(4);
    total_cnt++;
    if ({bus.radioEnableSynced, bus.radioRxEnSynced} !== 2'b11)
      $display("FAIL pre_reset_active: got %b expected 11", {bus.radioEnableSynced, bus.radioRxEnSynced});
    else pass_cnt++;
    bus.tArstFs = 8'd2;
    rstN = 1'b0;
    #1;
    total_cnt++;
    if ({bus.radioEnableSynced, bus.radioRxEnSynced, bus.busy} !== 3'b000)
      $display("FAIL async_reset_outs: got %b expected 000", {bus.radioEnableSynced, bus.radioRxEnSynced, bus.busy});
    else pass_cnt++;
    tick(2);
    rstN = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      exp_en   = (e >= 6);
      exp_busy = (e >= 3) && (e <= 5);
      total_cnt++;
      if (bus.radioEnableSynced !== exp_en) $display("FAIL post_reset_en edge %0d: got %b expected %b", e, bus.radioEnableSynced, exp_en);
      else pass_cnt++;
      total_cnt++;
      if (bus.radioRxEnSynced !== exp_en) $display("FAIL post_reset_rx edge %0d: got %b expected %b", e, bus.radioRxEnSynced, exp_en);
      else pass_cnt++;
      total_cnt++;
      if (bus.busy !== exp_busy) $display("FAIL post_reset_busy edge %0d: got %b expected %b", e, bus.busy, exp_busy);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    go_idle();
    test_zero_delay();
    go_idle();
    test_pll_wait();
    test_rx_toggle();
    test_abort();
    test_pll_loss();
    test_async_reset();
    go_idle();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
